// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
// Stalls the pipeline while busy and delivers {HI=remainder, LO=quotient}.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata_a,
  input  logic [WIDTH-1:0]   opdata_b,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               div_stall
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT              state;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   divisorReg;
  logic [WIDTH-1:0]   quotReg;
  logic [WIDTH-1:0]   remReg;
  logic               signQ;
  logic               signR;
  logic [2*WIDTH-1:0] finalReg;
  logic [2*WIDTH-1:0] lastResult;

  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               qBit;
  logic [WIDTH-1:0]   nextRem;
  logic [WIDTH-1:0]   nextQuot;
  logic [WIDTH-1:0]   fixedQuot;
  logic [WIDTH-1:0]   fixedRem;

  assign aNeg = signed_div & opdata_a[WIDTH-1];
  assign bNeg = signed_div & opdata_b[WIDTH-1];
  assign absA = aNeg ? -opdata_a : opdata_a;
  assign absB = bNeg ? -opdata_b : opdata_b;

  // quotReg shifts dividend bits out of the top while quotient bits enter at the bottom
  assign shifted   = {remReg, quotReg[WIDTH-1]};
  assign trial     = shifted - {1'b0, divisorReg};
  assign qBit      = ~trial[WIDTH];
  assign nextRem   = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign nextQuot  = {quotReg[WIDTH-2:0], qBit};
  assign fixedQuot = signQ ? -nextQuot : nextQuot;
  assign fixedRem  = signR ? -nextRem : nextRem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      divisorReg <= '0;
      quotReg    <= '0;
      remReg     <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
      finalReg   <= '0;
      lastResult <= '0;
    end else if (annul) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            divisorReg <= absB;
            quotReg    <= absA;
            remReg     <= '0;
            signQ      <= aNeg ^ bNeg;
            signR      <= aNeg;
            counter    <= '0;
            if (opdata_b == '0) begin
              finalReg <= {opdata_a, {WIDTH{1'b1}}};
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          remReg  <= nextRem;
          quotReg <= nextQuot;
          if (counter == CNT_W'(WIDTH - 1)) begin
            finalReg <= {fixedRem, fixedQuot};
            state    <= DONE;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          lastResult <= finalReg;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An annul in the DONE cycle suppresses both the ready pulse and the result update
  assign ready     = (state == DONE) & ~annul & ~rst;
  assign result    = ready ? finalReg : lastResult;
  assign div_stall = start & ~ready & ~annul & ~rst;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level behavioural model plus directed
// literal checks and randomized operations.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata_a;
  logic [31:0] opdata_b;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        div_stall;

  int checks   = 0;
  int failures = 0;
  bit scramble = 1'b0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .opdata_a  (opdata_a),
    .opdata_b  (opdata_b),
    .annul     (annul),
    .result    (result),
    .ready     (ready),
    .div_stall (div_stall)
  );

  function automatic logic [63:0] refDivide(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: an accepted operation reports after WIDTH+1 cycles (1 for b==0); annul/rst drop it
  bit          mEnabled  = 1'b0;
  bit          mInFlight = 1'b0;
  bit          mInDone   = 1'b0;
  int          mLeft     = 0;
  logic [63:0] mPending  = '0;
  logic [63:0] mResult   = '0;

  always @(posedge clk) begin
    if (rst) begin
      mEnabled  = 1'b1;
      mInFlight = 1'b0;
      mInDone   = 1'b0;
      mResult   = '0;
    end else if (annul) begin
      mInFlight = 1'b0;
      mInDone   = 1'b0;
    end else if (mInDone) begin
      mInDone = 1'b0;
      mResult = mPending;
    end else if (mInFlight) begin
      if (mLeft == 0) begin
        mInFlight = 1'b0;
        mInDone   = 1'b1;
      end else begin
        mLeft--;
      end
    end else if (start) begin
      mPending = refDivide(opdata_a, opdata_b, signed_div);
      if (opdata_b == 32'd0) mInDone = 1'b1;
      else begin
        mInFlight = 1'b1;
        mLeft     = WIDTH - 1;
      end
    end
  end

  logic        expReady;
  logic        expStall;
  logic [63:0] expResult;

  always @(negedge clk) begin
    if (mEnabled) begin
      expReady  = mInDone & ~annul & ~rst;
      expStall  = start & ~expReady & ~annul & ~rst;
      expResult = expReady ? mPending : mResult;
      checkOutput("ready", {63'd0, ready}, {63'd0, expReady});
      checkOutput("div_stall", {63'd0, div_stall}, {63'd0, expStall});
      checkOutput("result", result, expResult);
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                               output int latency, output logic [63:0] res);
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sgn;
    opdata_a   = a;
    opdata_b   = b;
    annul      = 1'b0;
    latency    = -1;
    res        = 'x;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready) begin
        latency = c;
        res     = result;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        opdata_a   = $urandom;
        opdata_b   = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
    end
    checks++;
    if (latency < 0) begin
      failures++;
      $display("[TB] FAIL ready timeout actual=none required=ready within 100 cycles");
    end
  endtask

  task automatic annulStimulus(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                               input int annulCycle, output bit seen);
    seen = 1'b0;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sgn;
    opdata_a   = a;
    opdata_b   = b;
    annul      = 1'b0;
    for (int c = 0; c < annulCycle; c++) begin
      @(negedge clk);
      seen |= ready;
      @(posedge clk); #1;
    end
    annul = 1'b1;
    @(negedge clk);
    seen |= ready;
    @(posedge clk); #1;
    annul = 1'b0;
    start = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready;
    end
  endtask

  task automatic dropStart();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  int          lat;
  logic [63:0] res;
  bit          seen;

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata_a = '0; opdata_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset result", result, 64'd0);
    checkOutput("reset ready", {63'd0, ready}, 64'd0);
    checkOutput("reset stall", {63'd0, div_stall}, 64'd0);

    checkOutput("model -7/2", refDivide(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    checkOutput("model overflow", refDivide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});

    applyStimulus(32'd100, 32'd7, 1'b0, lat, res);
    checkOutput("divu 100/7 latency", 64'(lat), 64'd33);
    checkOutput("divu 100/7 result", res, {32'd2, 32'd14});
    dropStart();

    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
    checkOutput("div -7/2 result", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    dropStart();

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
    checkOutput("div overflow result", res, {32'd0, 32'h8000_0000});
    dropStart();

    applyStimulus(32'd5, 32'd0, 1'b0, lat, res);
    checkOutput("divu 5/0 latency", 64'(lat), 64'd1);
    checkOutput("divu 5/0 result", res, {32'd5, 32'hFFFF_FFFF});
    dropStart();

    annulStimulus(32'd100, 32'd7, 1'b0, 10, seen);
    checkOutput("annul no ready", {63'd0, seen}, 64'd0);
    checkOutput("annul result kept", result, {32'd5, 32'hFFFF_FFFF});
    applyStimulus(32'd9, 32'd3, 1'b0, lat, res);
    checkOutput("divu 9/3 latency", 64'(lat), 64'd33);
    checkOutput("divu 9/3 result", res, {32'd0, 32'd3});
    dropStart();

    applyStimulus(32'd100, 32'd7, 1'b0, lat, res);
    checkOutput("b2b first result", res, {32'd2, 32'd14});
    applyStimulus(32'd50, 32'd5, 1'b0, lat, res);
    checkOutput("b2b second latency", 64'(lat), 64'd33);
    checkOutput("b2b second result", res, {32'd0, 32'd10});
    dropStart();

    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata_a = 32'd1000; opdata_b = 32'd3;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst busy result", result, 64'd0);
    checkOutput("rst busy ready", {63'd0, ready}, 64'd0);
    checkOutput("rst busy stall", {63'd0, div_stall}, 64'd0);

    scramble = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      bit sgn;
      int kind;
      kind = $urandom_range(0, 6);
      a    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 1000));
      b    = $urandom;
      sgn  = 1'($urandom_range(0, 1));
      case (kind)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; sgn = 1'b1; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        annulStimulus(a, b, sgn, $urandom_range(0, 33), seen);
      end else begin
        applyStimulus(a, b, sgn, lat, res);
        checkOutput("rand latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
        checkOutput("rand result", res, refDivide(a, b, sgn));
        if ($urandom_range(0, 1) == 1) dropStart();
      end
    end
    scramble = 1'b0;
    dropStart();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
